fft_butterfly_scheduler: RTL



---
 rtl/fft_butterfly_scheduler_pkg.sv | 26 ++
 rtl/fft_butterfly_scheduler_fifo.sv | 37 +++
 rtl/fft_butterfly_scheduler.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fft_butterfly_scheduler_pkg.sv
// fft_butterfly_scheduler_pkg: FSM states, address-pair types and the per-butterfly address helper
package fft_butterfly_scheduler_pkg;
  localparam int MAX_LOG_N = 16;
  localparam int S_W = 5;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  typedef struct packed {
    logic [MAX_LOG_N-1:0] a;
    logic [MAX_LOG_N-1:0] b;
  } addr_pair_t;
  typedef struct packed {
    addr_pair_t           p;
    logic [MAX_LOG_N-1:0] tw;
  } bf_addr_t;
  function automatic bf_addr_t bf_addr(input logic [S_W-1:0] s, input logic [MAX_LOG_N-1:0] k,
                                       input int log_n);
    logic [MAX_LOG_N-1:0] span;
    logic [MAX_LOG_N-1:0] pos;
    bf_addr_t r;
    span = MAX_LOG_N'(1) << s;
    pos = k & (span - MAX_LOG_N'(1));
    r.p.a = ((k >> s) << (s + S_W'(1))) | pos;
    r.p.b = r.p.a | span;
    r.tw = pos << (S_W'(log_n - 1) - s);
    return r;
  endfunction
endpackage

// File: rtl/fft_butterfly_scheduler_fifo.sv
// fft_butterfly_scheduler_fifo: in-flight address-pair FIFO with combinational head
module fft_butterfly_scheduler_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop = pop_i & (cnt_q != '0);
  assign do_push = push_i & ((cnt_q != (AW+1)'(DEPTH)) | do_pop);
  assign head_o = mem_q[rp_q];
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(do_push);
      rp_q <= rp_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q] <= din_i;
endmodule

// File: rtl/fft_butterfly_scheduler.sv
// fft_butterfly_scheduler: issues butterfly reads per stage, aligns bf_start,
// and retires write-back addresses in issue order, draining between stages.
module fft_butterfly_scheduler
  import fft_butterfly_scheduler_pkg::*;
#(
  parameter int LOG_N = 4,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-2:0] tw_addr,
  output logic             bf_start,
  input  logic             bf_done,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int KW = LOG_N - 1;
  state_t state_q, state_d;
  logic [S_W-1:0] s_q, s_d, iss_s;
  logic [KW-1:0] k_q, k_d, iss_k;
  logic iss, done_d, fifo_empty, rd_en_q, done_q, err_q, unused_ad;
  logic [CW-1:0] cnt;
  logic [2*LOG_N-1:0] head;
  logic [LOG_N-1:0] rd_addr_a_q, rd_addr_b_q;
  logic [LOG_N-2:0] tw_addr_q;
  logic [RD_LATENCY-1:0] sr_q;
  logic [RD_LATENCY:0] sr_d;
  bf_addr_t ad;
  // Leaving DRAIN issues butterfly 0 of the next stage directly, so the first
  // read lands the cycle after the in-flight count reaches zero.
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    k_d = k_q;
    iss = 1'b0;
    iss_s = s_q;
    iss_k = k_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = ISSUE;
        s_d = '0;
        k_d = '0;
      end
      ISSUE: if (cnt < CW'(FIFO_DEPTH)) begin
        iss = 1'b1;
        k_d = k_q + KW'(1);
        state_d = &k_q ? DRAIN : ISSUE;
      end
      DRAIN: if (cnt == '0) begin
        if (s_q == S_W'(LOG_N - 1)) begin
          state_d = IDLE;
          done_d = 1'b1;
        end else begin
          iss = 1'b1;
          iss_s = s_q + S_W'(1);
          iss_k = '0;
          s_d = s_q + S_W'(1);
          k_d = KW'(1);
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign ad = bf_addr(iss_s, MAX_LOG_N'(iss_k), LOG_N);
  assign unused_ad = ^ad;
  assign sr_d = {sr_q, rd_en_q};
  assign wr_en = bf_done & ~fifo_empty;
  assign wr_addr_a = wr_en ? head[2*LOG_N-1:LOG_N] : '0;
  assign wr_addr_b = wr_en ? head[LOG_N-1:0] : '0;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
  assign rd_en = rd_en_q;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign tw_addr = tw_addr_q;
  assign bf_start = sr_q[RD_LATENCY-1];
  fft_butterfly_scheduler_fifo #(.DEPTH(FIFO_DEPTH), .W(2*LOG_N)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (iss),
    .pop_i  (wr_en),
    .din_i  ({ad.p.a[LOG_N-1:0], ad.p.b[LOG_N-1:0]}),
    .head_o (head),
    .empty_o(fifo_empty),
    .count_o(cnt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      s_q <= '0;
      k_q <= '0;
      rd_en_q <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q <= '0;
      sr_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      k_q <= k_d;
      rd_en_q <= iss;
      rd_addr_a_q <= iss ? ad.p.a[LOG_N-1:0] : '0;
      rd_addr_b_q <= iss ? ad.p.b[LOG_N-1:0] : '0;
      tw_addr_q <= iss ? ad.tw[LOG_N-2:0] : '0;
      sr_q <= sr_d[RD_LATENCY-1:0];
      done_q <= done_d;
      err_q <= err_q | (bf_done & fifo_empty);
    end
endmodule
